// File: rtl/midi_note_dec_if.sv
// Byte-in / note-event-out bundle between the UART receiver, the MIDI note
// decoder and the voice allocator.
interface midi_note_dec_if;
  logic [7:0] rxData_i;
  logic       rxValid_i;
  logic       noteOnStrb_o;
  logic       noteOffStrb_o;
  logic [6:0] note_o;
  logic [6:0] velocity_o;
  logic [3:0] ch_o;
  logic       runStat_o;

  modport master (
    output rxData_i, rxValid_i,
    input  noteOnStrb_o, noteOffStrb_o, note_o, velocity_o, ch_o, runStat_o
  );

  modport slave (
    input  rxData_i, rxValid_i,
    output noteOnStrb_o, noteOffStrb_o, note_o, velocity_o, ch_o, runStat_o
  );
endinterface

// File: rtl/midi_note_dec.sv
// MIDI channel-message parser with running status; emits one-cycle note-on /
// note-off strobes with note, velocity and channel held until the next event.
module midi_note_dec #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic           clk_i,
  input  logic           nrst_i,
  midi_note_dec_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_D1, ST_WAIT_D2} state_e;
  typedef enum logic [1:0] {EV_NONE, EV_ON, EV_OFF} evt_e;

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic       run_stat_q, run_stat_d;
  logic [6:0] d1_q, d1_d;

  // Completed-message stage: decoded at the consuming edge, published one edge later.
  evt_e       evt_q, evt_d;
  logic [6:0] evt_note_q, evt_note_d;
  logic [6:0] evt_vel_q, evt_vel_d;
  logic [3:0] evt_ch_q, evt_ch_d;

  logic       note_on_q, note_on_d;
  logic       note_off_q, note_off_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic [3:0] ch_q, ch_d;

  logic [3:0] msg_type;
  logic       ch_ok;

  assign msg_type = status_q[7:4];
  assign ch_ok    = OMNI || (status_q[3:0] == CHANNEL);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    run_stat_d = run_stat_q;
    d1_d       = d1_q;
    evt_d      = EV_NONE;
    evt_note_d = evt_note_q;
    evt_vel_d  = evt_vel_q;
    evt_ch_d   = evt_ch_q;

    if (bus.rxValid_i) begin
      if (bus.rxData_i[7]) begin
        // Real-time bytes (F8..FF) fall through untouched, even mid-message.
        if (bus.rxData_i[7:3] != 5'b11111) begin
          if (bus.rxData_i[7:4] == 4'hF) begin
            status_d   = 8'h00;
            run_stat_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            status_d   = bus.rxData_i;
            run_stat_d = 1'b1;
            state_d    = ST_WAIT_D1;
          end
        end
      end else begin
        case (state_q)
          ST_WAIT_D1: begin
            d1_d    = bus.rxData_i[6:0];
            state_d = (msg_type == 4'hC || msg_type == 4'hD) ? ST_WAIT_D1 : ST_WAIT_D2;
          end
          ST_WAIT_D2: begin
            state_d = ST_WAIT_D1;
            if (ch_ok && (msg_type == 4'h9 || msg_type == 4'h8)) begin
              evt_d      = (msg_type == 4'h9 && bus.rxData_i[6:0] != 7'd0) ? EV_ON : EV_OFF;
              evt_note_d = d1_q;
              evt_vel_d  = bus.rxData_i[6:0];
              evt_ch_d   = status_q[3:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    note_on_d  = (evt_q == EV_ON);
    note_off_d = (evt_q == EV_OFF);
    note_d     = note_q;
    vel_d      = vel_q;
    ch_d       = ch_q;
    if (evt_q != EV_NONE) begin
      note_d = evt_note_q;
      vel_d  = evt_vel_q;
      ch_d   = evt_ch_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= ST_IDLE;
      status_q   <= 8'h00;
      run_stat_q <= 1'b0;
      d1_q       <= 7'd0;
      evt_q      <= EV_NONE;
      evt_note_q <= 7'd0;
      evt_vel_q  <= 7'd0;
      evt_ch_q   <= 4'd0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      note_q     <= 7'd0;
      vel_q      <= 7'd0;
      ch_q       <= 4'd0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      run_stat_q <= run_stat_d;
      d1_q       <= d1_d;
      evt_q      <= evt_d;
      evt_note_q <= evt_note_d;
      evt_vel_q  <= evt_vel_d;
      evt_ch_q   <= evt_ch_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      ch_q       <= ch_d;
    end
  end

  assign bus.noteOnStrb_o  = note_on_q;
  assign bus.noteOffStrb_o = note_off_q;
  assign bus.note_o        = note_q;
  assign bus.velocity_o    = vel_q;
  assign bus.ch_o          = ch_q;
  assign bus.runStat_o     = run_stat_q;

endmodule

// File: tb/tb_midi_note_dec.sv
// Directed bench: an omni decoder and a channel-3-only decoder fed the same byte stream.
module tb_midi_note_dec;

  logic clk_i  = 1'b0;
  logic nrst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  midi_note_dec_if ifa ();
  midi_note_dec_if ifb ();

  midi_note_dec #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_a (
    .clk_i (clk_i),
    .nrst_i(nrst_i),
    .bus   (ifa.slave)
  );

  midi_note_dec #(.OMNI(1'b0), .CHANNEL(4'd3)) dut_b (
    .clk_i (clk_i),
    .nrst_i(nrst_i),
    .bus   (ifb.slave)
  );

  int total = 0;
  int bad   = 0;

  // Strobe monitor, sampled on the falling edge.
  int on_a = 0, off_a = 0, on_b = 0, off_b = 0, both_hi = 0;
  logic [6:0] last_on_note_a = '0, last_on_vel_a = '0;

  always @(negedge clk_i) begin
    if (ifa.noteOnStrb_o) begin
      on_a++;
      last_on_note_a = ifa.note_o;
      last_on_vel_a  = ifa.velocity_o;
    end
    if (ifa.noteOffStrb_o) off_a++;
    if (ifb.noteOnStrb_o)  on_b++;
    if (ifb.noteOffStrb_o) off_b++;
    if ((ifa.noteOnStrb_o && ifa.noteOffStrb_o) || (ifb.noteOnStrb_o && ifb.noteOffStrb_o))
      both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_i);
    ifa.rxData_i  = b;
    ifa.rxValid_i = 1'b1;
    ifb.rxData_i  = b;
    ifb.rxValid_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      ifa.rxValid_i = 1'b0;
      ifb.rxValid_i = 1'b0;
    end
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send(seq[i]);
    idle(4);
  endtask

  int on0, off0, onb0, offb0;

  task automatic snap();
    on0 = on_a; off0 = off_a; onb0 = on_b; offb0 = off_b;
  endtask

  initial begin
    ifa.rxData_i = 8'h00; ifa.rxValid_i = 1'b0;
    ifb.rxData_i = 8'h00; ifb.rxValid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_note", ifa.note_o, 0);
    check("rst_vel", ifa.velocity_o, 0);
    check("rst_ch", ifa.ch_o, 0);
    check("rst_strb", {ifa.noteOnStrb_o, ifa.noteOffStrb_o}, 0);
    check("rst_runstat", ifa.runStat_o, 0);
    nrst_i = 1'b1;
    idle(2);

    // Note-on with exact latency: strobe visible after the edge following the consuming edge.
    snap();
    send(8'h92); send(8'h3C); send(8'h64);
    idle(1);
    check("t1_not_yet", ifa.noteOnStrb_o, 0);
    idle(1);
    check("t1_on", ifa.noteOnStrb_o, 1);
    check("t1_off", ifa.noteOffStrb_o, 0);
    check("t1_note", ifa.note_o, 7'h3C);
    check("t1_vel", ifa.velocity_o, 7'h64);
    check("t1_ch", ifa.ch_o, 2);
    idle(1);
    check("t1_pulse_end", ifa.noteOnStrb_o, 0);
    check("t1_hold_note", ifa.note_o, 7'h3C);
    check("t1_runstat", ifa.runStat_o, 1);
    idle(2);
    check("t1_on_count", on_a - on0, 1);

    // Running status, velocity-0 note-off.
    snap();
    send_seq('{8'h90, 8'h40, 8'h7F, 8'h40, 8'h00});
    check("t2_on_count", on_a - on0, 1);
    check("t2_off_count", off_a - off0, 1);
    check("t2_on_note", last_on_note_a, 7'h40);
    check("t2_on_vel", last_on_vel_a, 7'h7F);
    check("t2_note", ifa.note_o, 7'h40);
    check("t2_vel", ifa.velocity_o, 0);
    check("t2_ch", ifa.ch_o, 0);
    check("t2_runstat", ifa.runStat_o, 1);

    // Real-time byte inside a note-off.
    snap();
    send_seq('{8'h80, 8'h45, 8'hF8, 8'h10});
    check("t3_off_count", off_a - off0, 1);
    check("t3_on_count", on_a - on0, 0);
    check("t3_note", ifa.note_o, 7'h45);
    check("t3_vel", ifa.velocity_o, 7'h10);

    // SysEx clears running status; trailing data ignored.
    snap();
    send(8'hF0);
    idle(1);
    check("t3_runstat_f0", ifa.runStat_o, 0);
    send_seq('{8'h01, 8'h02, 8'hF7, 8'h3C, 8'h40});
    check("t3_sysex_strb", (on_a - on0) + (off_a - off0), 0);
    check("t3_sysex_note", ifa.note_o, 7'h45);
    check("t3_runstat_end", ifa.runStat_o, 0);

    // Program change and control change produce nothing.
    snap();
    send_seq('{8'hC5, 8'h07, 8'hB0, 8'h07, 8'h64});
    check("t4_no_strb", (on_a - on0) + (off_a - off0), 0);
    check("t4_note_hold", ifa.note_o, 7'h45);
    check("t4_vel_hold", ifa.velocity_o, 7'h10);
    check("t4_ch_hold", ifa.ch_o, 0);
    send_seq('{8'h91, 8'h30, 8'h50});
    check("t4_on_count", on_a - on0, 1);
    check("t4_note", ifa.note_o, 7'h30);
    check("t4_vel", ifa.velocity_o, 7'h50);
    check("t4_ch", ifa.ch_o, 1);
    check("t4_b_silent", (on_b - onb0) + (off_b - offb0), 0);
    check("t4_b_note", ifb.note_o, 0);

    // Channel filter on the channel-3 decoder.
    snap();
    send_seq('{8'h94, 8'h3C, 8'h64});
    check("t5_b_ch4_none", (on_b - onb0) + (off_b - offb0), 0);
    check("t5_a_ch4", ifa.ch_o, 4);
    send_seq('{8'h93, 8'h3C, 8'h64});
    check("t5_b_on_count", on_b - onb0, 1);
    check("t5_b_ch", ifb.ch_o, 3);
    check("t5_b_note", ifb.note_o, 7'h3C);
    check("t5_b_vel", ifb.velocity_o, 7'h64);

    // Abandoned partial message.
    snap();
    send_seq('{8'h90, 8'h3C, 8'h91, 8'h20, 8'h30});
    check("t5_abandon_on", on_a - on0, 1);
    check("t5_abandon_off", off_a - off0, 0);
    check("t5_abandon_note", ifa.note_o, 7'h20);
    check("t5_abandon_vel", ifa.velocity_o, 7'h30);
    check("t5_abandon_ch", ifa.ch_o, 1);
    check("t5_b_ignores", (on_b - onb0) + (off_b - offb0), 0);

    // Asynchronous reset mid-message.
    send(8'h90); send(8'h3C);
    idle(1);
    #2 nrst_i = 1'b0;
    #1;
    check("t6_rst_note", ifa.note_o, 0);
    check("t6_rst_vel", ifa.velocity_o, 0);
    check("t6_rst_ch", ifa.ch_o, 0);
    check("t6_rst_runstat", ifa.runStat_o, 0);
    check("t6_rst_b_ch", ifb.ch_o, 0);
    @(negedge clk_i);
    nrst_i = 1'b1;
    snap();
    send_seq('{8'h50});
    check("t6_no_strb", (on_a - on0) + (off_a - off0), 0);
    check("t6_runstat", ifa.runStat_o, 0);
    check("t6_note", ifa.note_o, 0);

    check("never_both_strobes", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_note_dec.md
Name: midi_note_dec

Overview:
- Byte-stream MIDI channel-message decoder that produces the note-on/note-off strobe interface consumed by the oscillator voices.
- Sits between the UART receiver (byte + valid) and the voice allocator/osc bank.
- Parses status and data bytes, including running status, and emits one single-cycle strobe per complete note message with the note, velocity and channel held stable.
- All other messages are parsed for framing and discarded.

Parameters:
- OMNI, 1, 1 = accept all 16 channels; 0 = accept only channel CHANNEL.
- CHANNEL, 0, 4-bit channel number (0..15) used when OMNI=0.

Ports:
- clk_i  in  1  system clock
- nrst_i  in  1  asynchronous active-low reset
- rxData_i  in  8  received MIDI byte
- rxValid_i  in  1  one-cycle qualifier for rxData_i; a byte is consumed on every rising edge where it is high
- noteOnStrb_o  out  1  one-cycle pulse: note-on decoded
- noteOffStrb_o  out  1  one-cycle pulse: note-off decoded
- note_o  out  7  note number of the last emitted event
- velocity_o  out  7  velocity of the last emitted event
- ch_o  out  4  MIDI channel of the last emitted event
- runStat_o  out  1  running status currently valid (debug/observability)

Behaviour:
- Reset (async, nrst_i=0): all outputs 0, status register cleared, runStat_o=0, data counter=0, FSM in IDLE. Reset mid-message discards the partial message with no strobe.
- Byte classes: bit7=1 is a status byte; bit7=0 is a data byte. All input is ignored when rxValid_i=0.
- Real-time bytes 0xF8..0xFF: ignored entirely; state, counter and running status are unchanged, including mid-message.
- System common/exclusive 0xF0..0xF7: clear running status, go to IDLE. Data bytes after them (SysEx payload) are ignored until the next channel status byte.
- Channel status 0x80..0xEF: latch the status byte, set runStat_o=1, go to WAIT_D1. Any partial message in progress is abandoned.
- FSM states:
  - IDLE: data bytes are ignored.
  - WAIT_D1: a data byte is latched as d1.
    - Types 0xC/0xD (one data byte): message complete, return to WAIT_D1 under running status.
    - Otherwise: go to WAIT_D2.
  - WAIT_D2: a data byte is latched as d2, the message is complete, return to WAIT_D1 under running status.
- Completion actions (registered; outputs change on the edge after the consuming edge, i.e. one-cycle latency):
  - Type 0x9 with d2!=0: noteOnStrb_o=1 for exactly one cycle.
  - Type 0x9 with d2==0: noteOffStrb_o=1 with velocity_o=0.
  - Type 0x8: noteOffStrb_o=1 with velocity_o=d2 (release velocity).
  - In every note case, note_o=d1 and ch_o=status[3:0] update in the same cycle as the strobe.
  - Types 0xA/0xB/0xC/0xD/0xE: no strobe, and note_o/velocity_o/ch_o are unchanged.
- Channel filter: if OMNI=0 and status[3:0]!=CHANNEL, the message is parsed normally for framing but produces no strobe and no output update.
- noteOnStrb_o and noteOffStrb_o are never high in the same cycle. Back-to-back complete messages on consecutive valid bytes produce strobes on distinct cycles.
- note_o, velocity_o and ch_o hold their values between events.

Test Plan:
- Note-on: bytes 0x92,0x3C,0x64 on consecutive cycles -> one cycle after 0x64, noteOnStrb_o=1 for 1 cycle, note_o=0x3C, velocity_o=0x64, ch_o=2; noteOffStrb_o stays 0.
- Running status plus velocity-0 off: 0x90,0x40,0x7F,0x40,0x00 -> noteOn (note 0x40, vel 0x7F), then noteOff (note 0x40, vel 0); runStat_o=1 throughout.
- Real-time interleave and SysEx: 0x80,0x45,0xF8,0x10 -> noteOff note 0x45 vel 0x10 (0xF8 is transparent). Then 0xF0,0x01,0x02,0xF7,0x3C,0x40 -> no strobes, runStat_o=0 after 0xF0.
- Ignored types and framing: 0xC5,0x07,0xB0,0x07,0x64, then 0x91,0x30,0x50 -> only one noteOn (note 0x30, ch 1); outputs unchanged before it.
- Channel filter with OMNI=0, CHANNEL=3: 0x94,0x3C,0x64 -> no strobe; 0x93,0x3C,0x64 -> noteOn ch_o=3. Abandon case: 0x90,0x3C,0x91,0x20,0x30 -> only the noteOn note 0x20 ch 1.
- Reset mid-message: 0x90,0x3C, assert nrst_i low asynchronously between clock edges -> all outputs 0 immediately. Release, send 0x50 -> no strobe (IDLE, no running status).
